// File: rtl/buf_pkg.sv
// buf_pkg: shared constants and width helpers for the buf_fifo block
package buf_pkg;
    localparam int BUF_DEPTH_MIN = 2;

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/buf_fifo_ptr.sv
// buf_fifo_ptr: pointer register that wraps from DEPTH-1 to 0 on increment
module buf_fifo_ptr
    import buf_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = ptr_width(DEPTH)
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);
    logic [PW-1:0] ptr_q, ptr_d;

    // explicit compare so non-power-of-2 depths wrap correctly
    always_comb ptr_d = !inc_i ? ptr_q : (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);

    always_ff @(posedge ck) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;
endmodule

// File: rtl/buf_fifo.sv
// buf_fifo: W-bit, DEPTH-entry registered FIFO with valid/ready handshakes and fill level
module buf_fifo
    import buf_pkg::*;
#(
    parameter int  W     = 8,
    parameter int  DEPTH = 4,
    localparam int LW    = level_width(DEPTH)
) (
    input  logic          ck,
    input  logic          rst,
    input  logic [W-1:0]  i,
    input  logic          i_valid,
    output logic          i_ready,
    output logic [W-1:0]  q,
    output logic          q_valid,
    input  logic          q_ready,
    output logic [LW-1:0] level
);
    localparam int PW = ptr_width(DEPTH);

    if (W < 1) begin : g_w_chk
        $error("buf_fifo: W must be at least 1");
    end
    if (DEPTH < BUF_DEPTH_MIN) begin : g_depth_chk
        $error("buf_fifo: DEPTH below BUF_DEPTH_MIN");
    end

    logic [W-1:0]  mem_q [DEPTH];
    logic [LW-1:0] level_q, level_d;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;

    assign i_ready = (level_q != LW'(DEPTH));
    assign q_valid = (level_q != '0);
    assign q       = mem_q[rd_ptr];
    assign level   = level_q;
    assign push    = i_valid & i_ready;
    assign pop     = q_valid & q_ready;

    always_comb level_d = (push & ~pop) ? level_q + LW'(1) : (pop & ~push) ? level_q - LW'(1) : level_q;

    always_ff @(posedge ck) begin
        if (rst) level_q <= '0;
        else     level_q <= level_d;
    end

    // storage only changes on reset or an accepted push
    always_ff @(posedge ck) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else if (push) begin
            mem_q[wr_ptr] <= i;
        end
    end

    buf_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .ck    (ck),
        .rst   (rst),
        .inc_i (push),
        .ptr_o (wr_ptr)
    );

    buf_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .ck    (ck),
        .rst   (rst),
        .inc_i (pop),
        .ptr_o (rd_ptr)
    );
endmodule

// File: tb/tb_buf_fifo.sv
// tb_buf_fifo: vector table, directed corner sequences and queue-model random checks
module tb_buf_fifo;
    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic       a_rst = 1'b1, a_iv = 1'b0, a_qr = 1'b0;
    logic [7:0] a_d = '0;
    logic       a_ir, a_qv;
    logic [7:0] a_q;
    logic [2:0] a_lvl;

    logic       b_rst = 1'b1, b_iv = 1'b0, b_qr = 1'b0;
    logic [0:0] b_d = '0;
    logic       b_ir, b_qv;
    logic [0:0] b_q;
    logic [1:0] b_lvl;

    buf_fifo #(.W(8), .DEPTH(4)) dut_a (
        .ck(ck), .rst(a_rst), .i(a_d), .i_valid(a_iv), .i_ready(a_ir),
        .q(a_q), .q_valid(a_qv), .q_ready(a_qr), .level(a_lvl)
    );

    buf_fifo #(.W(1), .DEPTH(3)) dut_b (
        .ck(ck), .rst(b_rst), .i(b_d), .i_valid(b_iv), .i_ready(b_ir),
        .q(b_q), .q_valid(b_qv), .q_ready(b_qr), .level(b_lvl)
    );

    typedef struct {
        logic       rst, iv, qr;
        logic [7:0] d;
        logic       e_qv, e_ir;
        logic [2:0] e_lvl;
        logic [7:0] e_q;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] mq_a[$];
    logic       mq_b[$];
    int         checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    function automatic vec_t mk(logic rst, logic iv, logic [7:0] d, logic qr,
                                logic e_qv, logic e_ir, logic [2:0] e_lvl, logic [7:0] e_q);
        vec_t v;
        v.rst = rst; v.iv = iv; v.d = d; v.qr = qr;
        v.e_qv = e_qv; v.e_ir = e_ir; v.e_lvl = e_lvl; v.e_q = e_q;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //                 rst iv  d      qr   qv  ir  lvl  q
        tbl.push_back(mk(1, 1, 8'hFF, 0,   0, 1, 0, 8'h00));
        tbl.push_back(mk(1, 1, 8'hFF, 0,   0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 1, 8'h11, 0,   1, 1, 1, 8'h11));
        tbl.push_back(mk(0, 1, 8'h22, 0,   1, 1, 2, 8'h11));
        tbl.push_back(mk(0, 1, 8'h33, 0,   1, 1, 3, 8'h11));
        tbl.push_back(mk(0, 1, 8'h44, 0,   1, 0, 4, 8'h11));
        tbl.push_back(mk(0, 1, 8'h55, 0,   1, 0, 4, 8'h11));
        tbl.push_back(mk(0, 0, 8'h00, 1,   1, 1, 3, 8'h22));
        tbl.push_back(mk(0, 0, 8'h00, 1,   1, 1, 2, 8'h33));
        tbl.push_back(mk(0, 0, 8'h00, 1,   1, 1, 1, 8'h44));
        tbl.push_back(mk(0, 0, 8'h00, 1,   0, 1, 0, 8'h11));
        tbl.push_back(mk(0, 0, 8'h00, 1,   0, 1, 0, 8'h11));
        tbl.push_back(mk(0, 1, 8'hA0, 0,   1, 1, 1, 8'hA0));
        tbl.push_back(mk(0, 1, 8'hA1, 0,   1, 1, 2, 8'hA0));
        tbl.push_back(mk(0, 1, 8'hA2, 0,   1, 1, 3, 8'hA0));
        tbl.push_back(mk(0, 1, 8'hA3, 0,   1, 0, 4, 8'hA0));
        tbl.push_back(mk(0, 1, 8'hA4, 1,   1, 1, 3, 8'hA1));
        tbl.push_back(mk(0, 1, 8'hA4, 0,   1, 0, 4, 8'hA1));

        foreach (tbl[n]) begin
            a_rst = tbl[n].rst; a_iv = tbl[n].iv; a_d = tbl[n].d; a_qr = tbl[n].qr;
            step();
            chk($sformatf("vec%0d q_valid", n), 32'(a_qv), 32'(tbl[n].e_qv));
            chk($sformatf("vec%0d i_ready", n), 32'(a_ir), 32'(tbl[n].e_ir));
            chk($sformatf("vec%0d level", n), 32'(a_lvl), 32'(tbl[n].e_lvl));
            chk($sformatf("vec%0d q", n), 32'(a_q), 32'(tbl[n].e_q));
        end

        // streaming: one word per cycle with a single cycle of latency
        a_rst = 1; a_iv = 0; a_qr = 0; step(); a_rst = 0;
        for (int k = 0; k < 24; k++) begin
            a_iv = 1; a_qr = 1; a_d = 8'(k);
            step();
            chk($sformatf("stream%0d q", k), 32'(a_q), k);
            chk($sformatf("stream%0d level", k), 32'(a_lvl), 1);
            chk($sformatf("stream%0d q_valid", k), 32'(a_qv), 1);
        end
        a_iv = 0; a_qr = 0;

        // random traffic on DEPTH=4 against a queue model
        a_rst = 1; step(); a_rst = 0;
        mq_a.delete();
        for (int k = 0; k < 200; k++) begin
            logic mpush, mpop;
            a_iv = 1'($urandom); a_qr = 1'($urandom); a_d = 8'($urandom);
            mpush = a_iv && (mq_a.size() != 4);
            mpop  = a_qr && (mq_a.size() != 0);
            if (mpop) void'(mq_a.pop_front());
            if (mpush) mq_a.push_back(a_d);
            step();
            chk($sformatf("randA%0d level", k), 32'(a_lvl), mq_a.size());
            chk($sformatf("randA%0d i_ready", k), 32'(a_ir), 32'(mq_a.size() != 4));
            chk($sformatf("randA%0d q_valid", k), 32'(a_qv), 32'(mq_a.size() != 0));
            if (mq_a.size() != 0) chk($sformatf("randA%0d q", k), 32'(a_q), 32'(mq_a[0]));
        end
        a_iv = 0; a_qr = 0;

        // reset in the middle of traffic discards stored words and the concurrent push
        a_rst = 1; step(); a_rst = 0;
        a_iv = 1; a_d = 8'h01; step();
        a_d = 8'h02; step();
        chk("midrst pre level", 32'(a_lvl), 2);
        a_rst = 1; a_d = 8'hAA; step();
        chk("midrst level", 32'(a_lvl), 0);
        chk("midrst q_valid", 32'(a_qv), 0);
        chk("midrst q", 32'(a_q), 0);
        a_rst = 0; a_d = 8'hBB; step();
        chk("midrst next q", 32'(a_q), 32'hBB);
        chk("midrst next level", 32'(a_lvl), 1);
        a_iv = 0; a_qr = 1; step();
        chk("midrst drained q_valid", 32'(a_qv), 0);
        chk("midrst drained level", 32'(a_lvl), 0);
        a_qr = 0;

        // non-power-of-2 depth with random handshakes
        b_rst = 1; step(); b_rst = 0;
        chk("randB reset level", 32'(b_lvl), 0);
        mq_b.delete();
        for (int k = 0; k < 80; k++) begin
            logic mpush, mpop;
            b_iv = 1'($urandom); b_qr = 1'($urandom_range(0, 2) == 0); b_d = 1'($urandom);
            mpush = b_iv && (mq_b.size() != 3);
            mpop  = b_qr && (mq_b.size() != 0);
            if (mpop) void'(mq_b.pop_front());
            if (mpush) mq_b.push_back(b_d[0]);
            step();
            chk($sformatf("randB%0d level", k), 32'(b_lvl), mq_b.size());
            chk($sformatf("randB%0d i_ready", k), 32'(b_ir), 32'(mq_b.size() != 3));
            chk($sformatf("randB%0d q_valid", k), 32'(b_qv), 32'(mq_b.size() != 0));
            if (mq_b.size() != 0) chk($sformatf("randB%0d q", k), 32'(b_q), 32'(mq_b[0]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
